hub75_capture: RTL and testbench

HUB75_CAPTURE -- requirements
Module: hub75_capture

---
 rtl/hub75_capture.sv | 173 +++++++++++++++++
 tb/tb_hub75_capture.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 panel bus capture: samples the shift/latch pins, keeps each complete row,
// and replays it as a valid/ready pixel stream with length, OE and overrun diagnostics.
//
// state | meaning
// IDLE  | holding buffer empty, no beat presented
// DRAIN | holding buffer owns a row, beats presented in column order
module hub75_capture #(
    parameter int NUM_COLS  = 64,
    parameter int SCAN_RATE = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          hub75_clk,
    input  logic [2:0]                    hub75_rgb0,
    input  logic [2:0]                    hub75_rgb1,
    input  logic                          hub75_latch,
    input  logic                          hub75_OE,
    input  logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(SCAN_RATE)-1:0]  out_addr,
    output logic [$clog2(NUM_COLS)-1:0]   out_col,
    output logic [2:0]                    out_rgb0,
    output logic [2:0]                    out_rgb1,
    output logic                          out_last,
    output logic                          len_err,
    output logic                          oe_err,
    output logic [7:0]                    drop_count
);

    localparam int ADDR_W = $clog2(SCAN_RATE);
    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int CNT_W  = $clog2(NUM_COLS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state;
    logic              s_clk, s_latch, s_oe;
    logic [2:0]        s_rgb0, s_rgb1;
    logic [ADDR_W-1:0] s_addr;
    logic              p_clk, p_latch;
    logic [1:0]        warm;

    logic [CNT_W-1:0]  shift_cnt;
    logic [CNT_W-1:0]  eff_cnt;
    logic [COL_W-1:0]  wr_idx;
    logic [COL_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] buf_addr;

    logic [2:0] shift_rgb0 [NUM_COLS];
    logic [2:0] shift_rgb1 [NUM_COLS];
    logic [2:0] nxt_rgb0   [NUM_COLS];
    logic [2:0] nxt_rgb1   [NUM_COLS];
    logic [2:0] buf_rgb0   [NUM_COLS];
    logic [2:0] buf_rgb1   [NUM_COLS];

    logic shift_edge, latch_edge, do_shift, row_ok;
    logic fire, last_fire, buf_free, accept, drop;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s_clk   <= 1'b0;
            s_latch <= 1'b0;
            s_oe    <= 1'b0;
            s_rgb0  <= '0;
            s_rgb1  <= '0;
            s_addr  <= '0;
            p_clk   <= 1'b0;
            p_latch <= 1'b0;
            warm    <= 2'b00;
        end else begin
            s_clk   <= hub75_clk;
            s_latch <= hub75_latch;
            s_oe    <= hub75_OE;
            s_rgb0  <= hub75_rgb0;
            s_rgb1  <= hub75_rgb1;
            s_addr  <= hub75_addr;
            p_clk   <= s_clk;
            p_latch <= s_latch;
            warm    <= {warm[0], 1'b1};
        end
    end

    // The zeroed history would make a pin already high at release look like an
    // edge; edges are only trusted once the history holds real samples.
    assign shift_edge = warm[1] & s_clk & ~p_clk;
    assign latch_edge = warm[1] & s_latch & ~p_latch;

    assign do_shift  = shift_edge && (shift_cnt < FULL_CNT);
    assign wr_idx    = shift_cnt[COL_W-1:0];
    assign eff_cnt   = do_shift ? shift_cnt + CNT_W'(1) : shift_cnt;
    assign row_ok    = latch_edge && (eff_cnt == FULL_CNT);

    assign fire      = (state == DRAIN) && out_ready;
    assign last_fire = fire && (rd_idx == LAST_COL);
    assign buf_free  = (state == IDLE) || last_fire;
    assign accept    = row_ok && buf_free;
    assign drop      = row_ok && !buf_free;

    // Row as it stands after this cycle's shift, so a same-cycle latch sees the final pixel.
    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) begin
            if (do_shift && (wr_idx == COL_W'(i))) begin
                nxt_rgb0[i] = s_rgb0;
                nxt_rgb1[i] = s_rgb1;
            end else begin
                nxt_rgb0[i] = shift_rgb0[i];
                nxt_rgb1[i] = shift_rgb1[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_shift) begin
            shift_rgb0[wr_idx] <= s_rgb0;
            shift_rgb1[wr_idx] <= s_rgb1;
        end
        if (accept) begin
            buf_rgb0 <= nxt_rgb0;
            buf_rgb1 <= nxt_rgb1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            rd_idx     <= '0;
            buf_addr   <= '0;
            shift_cnt  <= '0;
            len_err    <= 1'b0;
            oe_err     <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (latch_edge) begin
                shift_cnt <= '0;
            end else if (do_shift) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end

            if (latch_edge && !s_oe) begin
                oe_err <= 1'b1;
            end
            if (latch_edge && (eff_cnt != FULL_CNT)) begin
                len_err <= 1'b1;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            if (accept) begin
                state    <= DRAIN;
                rd_idx   <= '0;
                buf_addr <= s_addr;
            end else if (last_fire) begin
                state  <= IDLE;
                rd_idx <= '0;
            end else if (fire) begin
                rd_idx <= rd_idx + COL_W'(1);
            end
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_col   = rd_idx;
    assign out_addr  = buf_addr;
    assign out_last  = out_valid && (rd_idx == LAST_COL);
    assign out_rgb0  = out_valid ? buf_rgb0[rd_idx] : 3'b000;
    assign out_rgb1  = out_valid ? buf_rgb1[rd_idx] : 3'b000;

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives the panel pins at pixel level and compares the
// beat stream against rows modelled directly from the data shifted in.
module tb_hub75_capture;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       hub75_clk = 1'b0;
    logic [2:0] hub75_rgb0 = 3'd0;
    logic [2:0] hub75_rgb1 = 3'd0;
    logic       hub75_latch = 1'b0;
    logic       hub75_OE = 1'b1;
    logic [4:0] hub75_addr = 5'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [4:0] out_addr;
    logic [5:0] out_col;
    logic [2:0] out_rgb0, out_rgb1;
    logic       out_last, len_err, oe_err;
    logic [7:0] drop_count;

    hub75_capture #(.NUM_COLS(64), .SCAN_RATE(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hub75_clk(hub75_clk), .hub75_rgb0(hub75_rgb0), .hub75_rgb1(hub75_rgb1),
        .hub75_latch(hub75_latch), .hub75_OE(hub75_OE), .hub75_addr(hub75_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_col(out_col), .out_rgb0(out_rgb0), .out_rgb1(out_rgb1),
        .out_last(out_last), .len_err(len_err), .oe_err(oe_err),
        .drop_count(drop_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0] addr;
        logic [5:0] col;
        logic [2:0] r0;
        logic [2:0] r1;
        logic       last;
    } beat_t;

    beat_t      got_q[$];
    int         got_cyc[$];
    beat_t      exp_q[$];
    beat_t      cur_beat, held;
    logic       stalled = 1'b0;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] pix0 [64];
    logic [2:0] pix1 [64];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Beat collector: samples just before each rising edge; also checks that a
    // stalled beat stays put until it is taken.
    always @(negedge clk_in) begin
        #4;
        if (!rst_in && out_valid) begin
            cur_beat = {out_addr, out_col, out_rgb0, out_rgb1, out_last};
            if (stalled) begin
                n_total++;
                if (cur_beat !== held)
                    $display("FAIL hold_stable got=%h required=%h", cur_beat, held);
                else
                    n_pass++;
            end
            if (out_ready) begin
                got_q.push_back(cur_beat);
                got_cyc.push_back(cyc);
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = cur_beat;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Reference: an accepted row is replayed as columns 0..63 carrying the pixels shifted in.
    task automatic model_row(input logic [4:0] a);
        for (int c = 0; c < 64; c++)
            exp_q.push_back({a, 6'(c), pix0[c], pix1[c], (c == 63)});
    endtask

    task automatic rand_row();
        for (int i = 0; i < 64; i++) begin
            pix0[i] = 3'($urandom);
            pix1[i] = 3'($urandom);
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic shift_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            hub75_rgb0 = pix0[i];
            hub75_rgb1 = pix1[i];
            hub75_clk  = 1'b1;
            @(negedge clk_in);
            hub75_clk  = 1'b0;
            hub75_rgb0 = 3'($urandom);
            hub75_rgb1 = 3'($urandom);
        end
    endtask

    task automatic latch_row(input logic [4:0] a, input logic oe);
        @(negedge clk_in);
        hub75_addr  = a;
        hub75_OE    = oe;
        hub75_latch = 1'b1;
        @(negedge clk_in);
        hub75_latch = 1'b0;
        hub75_OE    = 1'b1;
        hub75_addr  = 5'($urandom);
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        rst_in     = 1'b1;
        hub75_clk  = 1'b1;
        hub75_rgb0 = 3'd5;
        hub75_rgb1 = 3'd2;
        repeat (3) @(negedge clk_in);
        #4;
        n_total++;
        if ({out_valid, out_last, out_col, out_addr, out_rgb0, out_rgb1, len_err, oe_err, drop_count} !== 29'd0)
            $display("FAIL reset_outputs got=%b required=0",
                     {out_valid, out_last, out_col, out_addr, out_rgb0, out_rgb1, len_err, oe_err, drop_count});
        else
            n_pass++;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        hub75_clk = 1'b0;
        #4;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_release_valid got=%b required=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pix0[i] = 3'(i);
            pix1[i] = ~3'(i);
        end
        model_row(5'd5);
        shift_pixels(64);
        @(negedge clk_in);
        hub75_addr = 5'd5;
        hub75_OE = 1'b1;
        hub75_latch = 1'b1;
        @(negedge clk_in);
        hub75_latch = 1'b0;
        hub75_addr = 5'd17;
        #4;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL latency_n1 got=%b required=0", out_valid);
        else n_pass++;
        @(negedge clk_in);
        #4;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL latency_n2 got=%b required=1", out_valid);
        else n_pass++;
        wait_beats(64, ok);
        n_total++;
        if (!ok) $display("FAIL basic_count got=%0d required=64", got_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        if (ok) begin
            n_total++;
            if (got_cyc[63] - got_cyc[0] != 63)
                $display("FAIL basic_no_bubbles got=%0d required=63", got_cyc[63] - got_cyc[0]);
            else
                n_pass++;
        end
        n_total++;
        if ({len_err, oe_err, drop_count} !== 10'd0)
            $display("FAIL basic_flags got=%b required=0", {len_err, oe_err, drop_count});
        else
            n_pass++;
    endtask

    task automatic test_short_row();
        bit ok;
        logic [4:0] a;
        clear_q();
        out_ready = 1'b1;
        rand_row();
        shift_pixels(63);
        latch_row(5'($urandom), 1'b1);
        repeat (6) @(negedge clk_in);
        #4;
        n_total++;
        if (len_err !== 1'b1) $display("FAIL short_len_err got=%b required=1", len_err);
        else n_pass++;
        n_total++;
        if (got_q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL short_no_valid got=%0d beats required=0", got_q.size());
        else
            n_pass++;
        // Next row: its 64th shift edge coincides with the latch edge.
        rand_row();
        a = 5'($urandom);
        model_row(a);
        shift_pixels(63);
        @(negedge clk_in);
        hub75_rgb0 = pix0[63];
        hub75_rgb1 = pix1[63];
        hub75_clk = 1'b1;
        hub75_addr = a;
        hub75_latch = 1'b1;
        @(negedge clk_in);
        hub75_clk = 1'b0;
        hub75_latch = 1'b0;
        hub75_addr = ~a;
        wait_beats(64, ok);
        n_total++;
        if (!ok) $display("FAIL short_next_count got=%0d required=64", got_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL short_next_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (drop_count !== 8'd0) $display("FAIL short_drop got=%0d required=0", drop_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [4:0] ab;
        clear_q();
        out_ready = 1'b0;
        rand_row();
        model_row(5'($urandom));
        shift_pixels(64);
        latch_row(exp_q[0].addr, 1'b1);
        rand_row();
        ab = 5'($urandom);
        model_row(ab);
        shift_pixels(64);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            if (out_valid && out_col == 6'd63) begin
                out_ready = 1'b0;
                break;
            end
            out_ready = 1'b1;
        end
        hub75_addr = ab;
        hub75_OE = 1'b1;
        hub75_latch = 1'b1;
        @(negedge clk_in);
        out_ready = 1'b1;
        hub75_latch = 1'b0;
        wait_beats(128, ok);
        n_total++;
        if (!ok) $display("FAIL b2b_count got=%0d required=128", got_q.size());
        else n_pass++;
        for (int i = 0; i < 128 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        if (ok) begin
            n_total++;
            if (got_cyc[64] - got_cyc[63] != 1)
                $display("FAIL b2b_continuous got=%0d required=1", got_cyc[64] - got_cyc[63]);
            else
                n_pass++;
        end
        n_total++;
        if (drop_count !== 8'd0) $display("FAIL b2b_drop got=%0d required=0", drop_count);
        else n_pass++;
    endtask

    task automatic test_oe_backpressure();
        logic [4:0] a;
        clear_q();
        out_ready = 1'b1;
        rand_row();
        a = 5'($urandom);
        model_row(a);
        shift_pixels(64);
        latch_row(a, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_in);
            if (got_q.size() >= 64) break;
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        n_total++;
        if (oe_err !== 1'b1) $display("FAIL oe_err got=%b required=1", oe_err);
        else n_pass++;
        n_total++;
        if (got_q.size() != 64) $display("FAIL oe_count got=%0d required=64", got_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL oe_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        bit ok;
        logic [4:0] a;
        clear_q();
        out_ready = 1'b0;
        rand_row();
        a = 5'($urandom);
        model_row(a);
        shift_pixels(64);
        latch_row(a, 1'b1);
        rand_row();
        shift_pixels(64);
        latch_row(5'($urandom), 1'b1);
        repeat (3) @(negedge clk_in);
        #4;
        n_total++;
        if (drop_count !== 8'd1) $display("FAIL drop_one got=%0d required=1", drop_count);
        else n_pass++;
        for (int r = 0; r < 300; r++) begin
            shift_pixels(64);
            latch_row(5'($urandom), 1'b1);
        end
        repeat (3) @(negedge clk_in);
        #4;
        n_total++;
        if (drop_count !== 8'd255) $display("FAIL drop_saturate got=%0d required=255", drop_count);
        else n_pass++;
        @(negedge clk_in);
        out_ready = 1'b1;
        wait_beats(64, ok);
        n_total++;
        if (!ok) $display("FAIL drop_first_count got=%0d required=64", got_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL drop_first_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_row();
        bit ok;
        logic [4:0] a;
        clear_q();
        out_ready = 1'b1;
        rand_row();
        shift_pixels(64);
        latch_row(5'($urandom), 1'b1);
        shift_pixels(5);
        for (int k = 0; k < 200; k++) begin
            if (got_q.size() >= 10) break;
            @(negedge clk_in);
        end
        rst_in = 1'b1;
        #9;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL midreset_valid got=%b required=0", out_valid);
        else n_pass++;
        n_total++;
        if ({len_err, oe_err, drop_count, out_last} !== 11'd0)
            $display("FAIL midreset_flags got=%b required=0", {len_err, oe_err, drop_count, out_last});
        else
            n_pass++;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        clear_q();
        rand_row();
        a = 5'($urandom);
        model_row(a);
        shift_pixels(64);
        latch_row(a, 1'b1);
        wait_beats(64, ok);
        n_total++;
        if (!ok) $display("FAIL fresh_count got=%0d required=64", got_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL fresh_beat%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if ({len_err, oe_err, drop_count} !== 10'd0)
            $display("FAIL fresh_flags got=%b required=0", {len_err, oe_err, drop_count});
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_row();
        test_back_to_back();
        test_oe_backpressure();
        test_drop();
        test_reset_mid_row();
        repeat (2) @(negedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
